irq_csr_unit: RTL and testbench

Parametrised machine-mode CSR and interrupt unit for the single-cycle RV32 core, replacing the fixed one-timer trap path with NUM_IRQ level-sensitive interrupt lines. It has a fixed priority encoder, direct/vectored mtvec, and a 64-bit mcycle counter. It sits beside the controller, takes the current pc and decoded CSR command, and drives the CSR read-data writeback input and the final PC-redirect mux (trap entry / mret).

---
 rtl/irq_csr_pkg.sv | 43 ++++
 rtl/irq_prio_enc.sv | 21 ++
 rtl/irq_csr_unit.sv | 167 ++++++++++++++++
 tb/tb_irq_csr_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/irq_csr_pkg.sv
// Shared definitions for the machine-mode CSR / interrupt unit: CSR addresses,
// command encoding, mstatus bit positions and interrupt cause mapping.
package irq_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

  typedef enum logic [1:0] {
    CSR_NONE  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_cmd_e;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  localparam logic [4:0] CAUSE_TIMER  = 5'd7;
  localparam logic [4:0] CAUSE_EXT    = 5'd11;
  localparam logic [4:0] CAUSE_LOCAL0 = 5'd16;

  // irq_in[0] is the timer, irq_in[1] the external line, the rest are local.
  function automatic logic [4:0] irq_cause(input int unsigned idx);
    if (idx == 0) return CAUSE_TIMER;
    if (idx == 1) return CAUSE_EXT;
    return CAUSE_LOCAL0 + 5'(idx - 2);
  endfunction

  function automatic logic [31:0] irq_cause_mask(input int unsigned n);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < n; i++) m[irq_cause(i)] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority interrupt encoder: external > timer > local lines ascending.
module irq_prio_enc
  import irq_csr_pkg::*;
(
  input  logic [31:0] pend_i,
  output logic        any_o,
  output logic [4:0]  code_o
);

  // NOTE: every output gets a default before the conditional overrides, so no latch is inferred.
  always_comb begin
    code_o = CAUSE_LOCAL0;
    for (int i = 31; i >= 16; i--) begin
      if (pend_i[i]) code_o = 5'(i);
    end
    if (pend_i[CAUSE_TIMER]) code_o = CAUSE_TIMER;
    if (pend_i[CAUSE_EXT])   code_o = CAUSE_EXT;
    any_o = |pend_i;
  end

endmodule

// File: rtl/irq_csr_unit.sv
// Machine-mode CSR file with level-sensitive interrupts, direct/vectored mtvec,
// a 64-bit mcycle counter and the trap-entry / mret PC redirect.
module irq_csr_unit
  import irq_csr_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = 4,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [11:0]        csr_addr,
  input  logic [1:0]         csr_cmd,
  input  logic [31:0]        csr_wdata,
  input  logic               is_mret,
  output logic [31:0]        csr_rdata,
  output logic               csr_illegal,
  output logic               trap_taken,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc
);

  localparam logic [31:0] IRQ_MASK = irq_cause_mask(NUM_IRQ);

  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mip_q, mip_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mcycle_q, mcycle_d;
  logic [31:0] mcycleh_q, mcycleh_d;

  csr_cmd_e    cmd;
  logic        csr_hit;
  logic        csr_we;
  logic [31:0] csr_wval;
  logic        irq_any;
  logic [4:0]  irq_code;
  logic [31:0] trap_pc;

  assign cmd = csr_cmd_e'(csr_cmd);

  irq_prio_enc u_prio (
    .pend_i (mip_q & mie_q),
    .any_o  (irq_any),
    .code_o (irq_code)
  );

  always_comb begin
    csr_hit   = 1'b1;
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MIE]  = mstatus_mie_q;
        csr_rdata[MSTATUS_MPIE] = mstatus_mpie_q;
      end
      CSR_MIE:      csr_rdata = mie_q;
      CSR_MIP:      csr_rdata = mip_q;
      CSR_MTVEC:    csr_rdata = mtvec_q;
      CSR_MSCRATCH: csr_rdata = mscratch_q;
      CSR_MEPC:     csr_rdata = mepc_q;
      CSR_MCAUSE:   csr_rdata = mcause_q;
      CSR_MCYCLE:   csr_rdata = mcycle_q;
      CSR_MCYCLEH:  csr_rdata = mcycleh_q;
      default:      csr_hit = 1'b0;
    endcase
  end

  always_comb begin
    case (cmd)
      CSR_WRITE: csr_wval = csr_wdata;
      CSR_SET:   csr_wval = csr_rdata | csr_wdata;
      CSR_CLEAR: csr_wval = csr_rdata & ~csr_wdata;
      default:   csr_wval = csr_rdata;
    endcase
  end

  assign trap_taken     = ~rst & mstatus_mie_q & irq_any;
  assign redirect_valid = ~rst & (trap_taken | is_mret);
  assign csr_illegal    = ~rst & (cmd != CSR_NONE) & ~csr_hit;
  // A trap kills the instruction in flight, including its CSR side effect.
  assign csr_we         = (cmd != CSR_NONE) & csr_hit & ~trap_taken;

  assign trap_pc     = {mtvec_q[31:2], 2'b00}
                     + ((mtvec_q[1:0] == 2'b01) ? {25'd0, irq_code, 2'b00} : 32'd0);
  assign redirect_pc = trap_taken ? trap_pc : mepc_q;

  always_comb begin
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      mip_d[irq_cause(i)] = irq_in[i];
    end
    mip_d          = mip_d & IRQ_MASK;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    if (csr_we) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mstatus_mie_d  = csr_wval[MSTATUS_MIE];
          mstatus_mpie_d = csr_wval[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_d      = csr_wval & IRQ_MASK;
        CSR_MTVEC:    mtvec_d    = {csr_wval[31:2], 1'b0, csr_wval[1:0] == 2'b01};
        CSR_MSCRATCH: mscratch_d = csr_wval;
        CSR_MEPC:     mepc_d     = {csr_wval[31:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = csr_wval;
        default: ;
      endcase
    end
    if (trap_taken) begin
      mepc_d         = {pc[31:2], 2'b00};
      mcause_d       = {1'b1, 26'd0, irq_code};
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (is_mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
  end

  // A written half is replaced outright; the low half only carries when unwritten.
  always_comb begin
    mcycle_d  = mcycle_q + 32'd1;
    mcycleh_d = mcycleh_q + {31'd0, mcycle_q == 32'hFFFF_FFFF};
    if (csr_we && csr_addr == CSR_MCYCLE) begin
      mcycle_d  = csr_wval;
      mcycleh_d = mcycleh_q;
    end
    if (csr_we && csr_addr == CSR_MCYCLEH) mcycleh_d = csr_wval;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mip_q          <= '0;
      mtvec_q        <= MTVEC_RESET;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mcycle_q       <= '0;
      mcycleh_q      <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mip_q          <= mip_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mcycle_q       <= mcycle_d;
      mcycleh_q      <= mcycleh_d;
    end
  end

endmodule

// File: tb/tb_irq_csr_unit.sv
// Directed vector bench for irq_csr_unit: a cycle-by-cycle CSR/interrupt
// program in a table, plus hand-written reset and mcycle carry sequences.
module tb_irq_csr_unit;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_BAD      = 12'h7C0;
  localparam logic [1:0]  NO = 2'b00, WR = 2'b01, ST = 2'b10, CL = 2'b11;
  localparam int NV = 42;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  irq;
    logic [11:0] addr;
    logic [1:0]  cmd;
    logic [31:0] wdata;
    logic        mret;
    logic [31:0] rdata;
    logic        ill;
    logic        trap;
    logic        rv;
    logic [31:0] rpc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [3:0]  irq_in;
  logic [11:0] csr_addr;
  logic [1:0]  csr_cmd;
  logic [31:0] csr_wdata;
  logic        is_mret;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        trap_taken;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_pass = 0;
  int n_total = 0;
  vec_t vecs [NV];

  irq_csr_unit #(.NUM_IRQ(4), .MTVEC_RESET(32'h0000_0100)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .irq_in         (irq_in),
    .csr_addr       (csr_addr),
    .csr_cmd        (csr_cmd),
    .csr_wdata      (csr_wdata),
    .is_mret        (is_mret),
    .csr_rdata      (csr_rdata),
    .csr_illegal    (csr_illegal),
    .trap_taken     (trap_taken),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic [31:0] p, input logic [3:0] irq, input logic [11:0] a,
                       input logic [1:0] c, input logic [31:0] wd, input logic mr);
    pc = p; irq_in = irq; csr_addr = a; csr_cmd = c; csr_wdata = wd; is_mret = mr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] p, input logic [3:0] irq, input logic [11:0] a,
                              input logic [1:0] c, input logic [31:0] wd, input logic mr,
                              input logic [31:0] rd, input logic il, input logic tr,
                              input logic rv, input logic [31:0] rpc);
    vec_t v;
    v.pc = p; v.irq = irq; v.addr = a; v.cmd = c; v.wdata = wd; v.mret = mr;
    v.rdata = rd; v.ill = il; v.trap = tr; v.rv = rv; v.rpc = rpc;
    return v;
  endfunction

  initial begin
    //              pc     irq      addr        cmd wdata        mret rdata         il tr rv rpc
    vecs[0]  = mk(32'h0,   4'b0000, A_MTVEC,    NO, 32'h0,        0, 32'h100,        0, 0, 0, 32'h0);
    vecs[1]  = mk(32'h0,   4'b0000, A_MSTATUS,  NO, 32'h0,        0, 32'h0,          0, 0, 0, 32'h0);
    vecs[2]  = mk(32'h0,   4'b0000, A_MIE,      WR, 32'h80,       0, 32'h0,          0, 0, 0, 32'h0);
    vecs[3]  = mk(32'h0,   4'b0000, A_MIE,      ST, 32'h800,      0, 32'h80,         0, 0, 0, 32'h0);
    vecs[4]  = mk(32'h0,   4'b0000, A_MIE,      CL, 32'h80,       0, 32'h880,        0, 0, 0, 32'h0);
    vecs[5]  = mk(32'h0,   4'b0000, A_MIE,      NO, 32'h0,        0, 32'h800,        0, 0, 0, 32'h0);
    vecs[6]  = mk(32'h0,   4'b0000, A_MTVEC,    WR, 32'hFFFF_FFFF,0, 32'h100,        0, 0, 0, 32'h0);
    vecs[7]  = mk(32'h0,   4'b0000, A_MTVEC,    NO, 32'h0,        0, 32'hFFFF_FFFC,  0, 0, 0, 32'h0);
    vecs[8]  = mk(32'h0,   4'b0000, A_MTVEC,    WR, 32'h202,      0, 32'hFFFF_FFFC,  0, 0, 0, 32'h0);
    vecs[9]  = mk(32'h0,   4'b0000, A_MTVEC,    NO, 32'h0,        0, 32'h200,        0, 0, 0, 32'h0);
    vecs[10] = mk(32'h0,   4'b0000, A_BAD,      ST, 32'h0,        0, 32'h0,          1, 0, 0, 32'h0);
    vecs[11] = mk(32'h0,   4'b0000, A_MIP,      WR, 32'hFFFF_FFFF,0, 32'h0,          0, 0, 0, 32'h0);
    vecs[12] = mk(32'h0,   4'b0000, A_MEPC,     WR, 32'h123,      0, 32'h0,          0, 0, 0, 32'h0);
    vecs[13] = mk(32'h0,   4'b0000, A_MEPC,     NO, 32'h0,        1, 32'h120,        0, 0, 1, 32'h120);
    vecs[14] = mk(32'h0,   4'b0000, A_MSTATUS,  NO, 32'h0,        0, 32'h80,         0, 0, 0, 32'h0);
    vecs[15] = mk(32'h0,   4'b0000, A_MIE,      WR, 32'h80,       0, 32'h800,        0, 0, 0, 32'h0);
    vecs[16] = mk(32'h0,   4'b0000, A_MSTATUS,  ST, 32'h8,        0, 32'h80,         0, 0, 0, 32'h0);
    vecs[17] = mk(32'h40,  4'b0001, A_MIP,      NO, 32'h0,        0, 32'h0,          0, 0, 0, 32'h0);
    vecs[18] = mk(32'h40,  4'b0001, A_MIP,      NO, 32'h0,        0, 32'h80,         0, 1, 1, 32'h200);
    vecs[19] = mk(32'h200, 4'b0001, A_MEPC,     NO, 32'h0,        0, 32'h40,         0, 0, 0, 32'h0);
    vecs[20] = mk(32'h204, 4'b0001, A_MCAUSE,   NO, 32'h0,        0, 32'h8000_0007,  0, 0, 0, 32'h0);
    vecs[21] = mk(32'h208, 4'b0000, A_MSTATUS,  NO, 32'h0,        0, 32'h80,         0, 0, 0, 32'h0);
    vecs[22] = mk(32'h0,   4'b0000, A_MTVEC,    WR, 32'h201,      0, 32'h200,        0, 0, 0, 32'h0);
    vecs[23] = mk(32'h0,   4'b0000, A_MIE,      WR, 32'h880,      0, 32'h80,         0, 0, 0, 32'h0);
    vecs[24] = mk(32'h0,   4'b0011, A_MTVEC,    NO, 32'h0,        0, 32'h201,        0, 0, 0, 32'h0);
    vecs[25] = mk(32'h0,   4'b0011, A_MSTATUS,  ST, 32'h8,        0, 32'h80,         0, 0, 0, 32'h0);
    vecs[26] = mk(32'h300, 4'b0011, A_MIP,      NO, 32'h0,        0, 32'h880,        0, 1, 1, 32'h22C);
    vecs[27] = mk(32'h22C, 4'b0000, A_MCAUSE,   NO, 32'h0,        1, 32'h8000_000B,  0, 0, 1, 32'h300);
    vecs[28] = mk(32'h300, 4'b0000, A_MSTATUS,  NO, 32'h0,        0, 32'h88,         0, 0, 0, 32'h0);
    vecs[29] = mk(32'h304, 4'b0000, A_MCAUSE,   NO, 32'h0,        0, 32'h8000_000B,  0, 0, 0, 32'h0);
    vecs[30] = mk(32'h4FC, 4'b0001, A_MSCRATCH, NO, 32'h0,        0, 32'h0,          0, 0, 0, 32'h0);
    vecs[31] = mk(32'h500, 4'b0001, A_MSCRATCH, WR, 32'hDEAD,     1, 32'h0,          0, 1, 1, 32'h21C);
    vecs[32] = mk(32'h21C, 4'b0000, A_MSCRATCH, NO, 32'h0,        0, 32'h0,          0, 0, 0, 32'h0);
    vecs[33] = mk(32'h220, 4'b0000, A_MEPC,     NO, 32'h0,        0, 32'h500,        0, 0, 0, 32'h0);
    vecs[34] = mk(32'h224, 4'b0000, A_MSTATUS,  NO, 32'h0,        0, 32'h80,         0, 0, 0, 32'h0);
    vecs[35] = mk(32'h0,   4'b0000, A_MIE,      ST, 32'h3_0000,   0, 32'h880,        0, 0, 0, 32'h0);
    vecs[36] = mk(32'h0,   4'b0000, A_MSTATUS,  ST, 32'h8,        0, 32'h80,         0, 0, 0, 32'h0);
    vecs[37] = mk(32'h0,   4'b1100, A_MIE,      NO, 32'h0,        0, 32'h3_0880,     0, 0, 0, 32'h0);
    vecs[38] = mk(32'h60,  4'b1100, A_MIP,      NO, 32'h0,        0, 32'h3_0000,     0, 1, 1, 32'h240);
    vecs[39] = mk(32'h240, 4'b0000, A_MCAUSE,   NO, 32'h0,        0, 32'h8000_0010,  0, 0, 0, 32'h0);
    vecs[40] = mk(32'h244, 4'b0000, A_MIE,      WR, 32'hFFFF_FFFF,0, 32'h3_0880,     0, 0, 0, 32'h0);
    vecs[41] = mk(32'h248, 4'b0000, A_MIE,      NO, 32'h0,        0, 32'h3_0880,     0, 0, 0, 32'h0);

    // Reset with every input active: outputs must stay quiet.
    rst = 1'b1;
    drive(32'h40, 4'b1111, A_BAD, WR, 32'hFFFF_FFFF, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst trap_taken", {31'd0, trap_taken}, 32'd0);
    check("rst redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("rst csr_illegal", {31'd0, csr_illegal}, 32'd0);
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      drive(32'h0, 4'b0000, A_MCYCLE, NO, 32'h0, 1'b0);
      @(negedge clk);
      check($sformatf("mcycle count %0d", i), csr_rdata, 32'(i));
      check("post-rst no trap", {31'd0, trap_taken}, 32'd0);
      next_cycle();
    end

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].pc, vecs[i].irq, vecs[i].addr, vecs[i].cmd, vecs[i].wdata, vecs[i].mret);
      @(negedge clk);
      check($sformatf("v%0d rdata", i), csr_rdata, vecs[i].rdata);
      check($sformatf("v%0d illegal", i), {31'd0, csr_illegal}, {31'd0, vecs[i].ill});
      check($sformatf("v%0d trap", i), {31'd0, trap_taken}, {31'd0, vecs[i].trap});
      check($sformatf("v%0d redirect_valid", i), {31'd0, redirect_valid}, {31'd0, vecs[i].rv});
      if (vecs[i].rv) check($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].rpc);
      next_cycle();
    end

    // mcycle low-half overflow carries into mcycleh.
    drive(32'h0, 4'b0000, A_MCYCLEH, WR, 32'd5, 1'b0);          next_cycle();
    drive(32'h0, 4'b0000, A_MCYCLE, WR, 32'hFFFF_FFFF, 1'b0);   next_cycle();
    drive(32'h0, 4'b0000, A_MCYCLE, NO, 32'h0, 1'b0);
    @(negedge clk); check("mcycle before wrap", csr_rdata, 32'hFFFF_FFFF); next_cycle();
    @(negedge clk); check("mcycle after wrap", csr_rdata, 32'h0);         next_cycle();
    drive(32'h0, 4'b0000, A_MCYCLEH, NO, 32'h0, 1'b0);
    @(negedge clk); check("mcycleh carry", csr_rdata, 32'd6);              next_cycle();

    // A write to mcycleh in the carry cycle wins over the carry.
    drive(32'h0, 4'b0000, A_MCYCLEH, WR, 32'd5, 1'b0);          next_cycle();
    drive(32'h0, 4'b0000, A_MCYCLE, WR, 32'hFFFF_FFFF, 1'b0);   next_cycle();
    drive(32'h0, 4'b0000, A_MCYCLEH, WR, 32'd0, 1'b0);
    @(negedge clk); check("mcycleh old in carry cycle", csr_rdata, 32'd5); next_cycle();
    drive(32'h0, 4'b0000, A_MCYCLEH, NO, 32'h0, 1'b0);
    @(negedge clk); check("mcycleh written over carry", csr_rdata, 32'd0); next_cycle();
    drive(32'h0, 4'b0000, A_MCYCLE, NO, 32'h0, 1'b0);
    @(negedge clk); check("mcycle after written carry", csr_rdata, 32'd1); next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
